rgb_to_gray_stream: RTL and testbench

Front-end stage of the histogram-equalization pipeline. It accepts one RGB888 pixel per handshake and converts it to 8-bit luma. It emits the gray pixel stream, with frame position markers, that feeds the histogram/equalization block. The block processes exactly one IMAGE_WIDTH×IMAGE_HEIGHT frame per `start` command, applies backpressure in both directions, and pulses `done` once the frame's last gray pixel has been delivered.

---
 rtl/rgb_to_gray_stream.sv | 169 ++++++++++++++++
 tb/tb_rgb_to_gray_stream.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_gray_stream.sv
// RGB888 to 8-bit luma conversion stage with frame position markers.
// Converts exactly one IMAGE_WIDTH x IMAGE_HEIGHT frame per start command.
module rgb_to_gray_stream #(
  parameter int unsigned IMAGE_WIDTH  = 660,
  parameter int unsigned IMAGE_HEIGHT = 440
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_pixel,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof,
  output logic       busy,
  output logic       done
);

  localparam int unsigned COL_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned SUM_W  = 17;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             en;
  logic             in_xfer;
  logic             out_xfer;
  logic             last_col;
  logic             last_row;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic              s1_valid;
  logic [PROD_W-1:0] s1_pr;
  logic [PROD_W-1:0] s1_pg;
  logic [PROD_W-1:0] s1_pb;
  logic              s1_sof;
  logic              s1_eol;
  logic              s1_eof;

  logic [SUM_W-1:0]  sum;
  logic [7:0]        luma;

  assign en       = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);
  assign busy     = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and input handshake
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        in_ready = en;
        if (in_valid && en && last_col && last_row) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_xfer && out_eof) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame position counters, advanced per accepted input pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (in_xfer) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Stage 1: weighted components and position tags
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_pr    <= '0;
      s1_pg    <= '0;
      s1_pb    <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (en) begin
      s1_valid <= in_xfer;
      if (in_xfer) begin
        s1_pr  <= PROD_W'(in_r) * PROD_W'(77);
        s1_pg  <= PROD_W'(in_g) * PROD_W'(150);
        s1_pb  <= PROD_W'(in_b) * PROD_W'(29);
        s1_sof <= (col == '0) && (row == '0);
        s1_eol <= last_col;
        s1_eof <= last_col && last_row;
      end
    end
  end

  // Coefficients sum to 256, so the rounded quotient always fits in 8 bits
  assign sum  = SUM_W'(s1_pr) + SUM_W'(s1_pg) + SUM_W'(s1_pb) + SUM_W'(128);
  assign luma = 8'(sum >> 8);

  // Stage 2: output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_pixel <= luma;
        out_sof   <= s1_sof;
        out_eol   <= s1_eol;
        out_eof   <= s1_eof;
      end
    end
  end

  // Completion pulse follows the final output transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= (state == DRAIN) && out_xfer && out_eof;
    end
  end

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Self-checking bench for rgb_to_gray_stream: constant vector table, directed
// corner sequences and randomized frames against a frame-index reference model.
module tb_rgb_to_gray_stream;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_r;
  logic [7:0] in_g;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixel;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;
  int last_in_cyc = 0;
  int tot_out = 0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  vec_t tbl [N];
  exp_t q[$];

  rgb_to_gray_stream #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_r     (in_r),
    .in_g     (in_g),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel),
    .out_sof  (out_sof),
    .out_eol  (out_eol),
    .out_eof  (out_eof),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // out_ready: 0 = held high, 1 = held low, 2 = random
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      else           out_ready = (mode == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_luma(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
    int s;
    s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b) + 128;
    return 8'(s / 256);
  endfunction

  // Reference model: frame phase, accepted-pixel index and expected output queue
  initial begin
    int   phase;
    int   n;
    int   fout;
    int   feol;
    int   fsof;
    bit   done_exp;
    bit   stall_prev;
    logic [7:0] prev_pix;
    logic [2:0] prev_tags;
    exp_t e;
    phase = 0; n = 0; fout = 0; feol = 0; fsof = 0;
    done_exp = 0; stall_prev = 0; prev_pix = '0; prev_tags = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        phase = 0; n = 0; fout = 0; feol = 0; fsof = 0;
        done_exp = 0; stall_prev = 0;
      end else begin
        chk("done", 32'(done), 32'(done_exp));
        if (phase != 1) chk("in_ready_off", 32'(in_ready), 0);
        if (stall_prev) begin
          chk("hold_valid", 32'(out_valid), 1);
          chk("hold_pixel", 32'(out_pixel), 32'(prev_pix));
          chk("hold_tags", 32'({out_sof, out_eol, out_eof}), 32'(prev_tags));
        end
        done_exp = 0;
        if (phase == 0 && start) begin
          phase = 1;
          n = 0;
        end else if (in_valid && in_ready) begin
          chk("in_phase", 32'(phase), 1);
          e.y   = ref_luma(in_r, in_g, in_b);
          e.sof = (n == 0);
          e.eol = ((n % W) == W - 1);
          e.eof = (n == N - 1);
          q.push_back(e);
          n++;
          if (n == N) phase = 2;
        end
        if (out_valid && out_ready) begin
          tot_out++;
          if (q.size() == 0) begin
            chk("unexpected_output", 32'(out_pixel), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("pixel", 32'(out_pixel), 32'(e.y));
            chk("sof", 32'(out_sof), 32'(e.sof));
            chk("eol", 32'(out_eol), 32'(e.eol));
            chk("eof", 32'(out_eof), 32'(e.eof));
          end
          fout++;
          feol += int'(out_eol);
          fsof += int'(out_sof);
          if (out_eof) begin
            chk("frame_outputs", 32'(fout), 32'(N));
            chk("frame_eols", 32'(feol), 32'(H));
            chk("frame_sofs", 32'(fsof), 1);
            chk("eof_phase", 32'(phase), 2);
            phase = 0;
            done_exp = 1;
            fout = 0; feol = 0; fsof = 0;
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_pix   = out_pixel;
        prev_tags  = {out_sof, out_eol, out_eof};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input int gap);
    bit got;
    got = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_r = r;
    in_g = g;
    in_b = b;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        last_in_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("send_timeout", 32'(got), 1);
  endtask

  task automatic send_rand(input int gap);
    send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), gap);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_timeout", 32'(seen), 1);
  endtask

  initial begin
    int t_in0;
    int t_out0;
    int base;
    bit sof_seen;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;
    t_in0 = 0; t_out0 = -100; base = 0; sof_seen = 0;

    tbl[0] = '{8'd200, 8'd200, 8'd200, 8'd200};
    tbl[1] = '{8'd255, 8'd0,   8'd0,   8'd77};
    tbl[2] = '{8'd0,   8'd255, 8'd0,   8'd149};
    tbl[3] = '{8'd0,   8'd0,   8'd255, 8'd29};
    tbl[4] = '{8'd255, 8'd255, 8'd255, 8'd255};
    tbl[5] = '{8'd0,   8'd0,   8'd0,   8'd0};
    tbl[6] = '{8'd100, 8'd50,  8'd25,  8'd62};
    tbl[7] = '{8'd12,  8'd34,  8'd56,  8'd30};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pixel", 32'(out_pixel), 0);
    chk("rst_tags", 32'({out_sof, out_eol, out_eof}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Constant vector frame under continuous handshake
    pulse_start();
    fork
      begin
        for (int i = 0; i < N; i++) begin
          send(tbl[i].r, tbl[i].g, tbl[i].b, 0);
          if (i == 0) t_in0 = last_in_cyc;
        end
        in_valid = 1'b0;
      end
      begin
        int k;
        k = 0;
        for (int c = 0; c < 100 && k < N; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            if (k == 0) t_out0 = cyc;
            chk("tbl_pixel", 32'(out_pixel), 32'(tbl[k].y));
            chk("tbl_sof", 32'(out_sof), 32'(k == 0));
            chk("tbl_eol", 32'(out_eol), 32'((k % W) == W - 1));
            chk("tbl_eof", 32'(out_eof), 32'(k == N - 1));
            k++;
          end
        end
        chk("tbl_count", 32'(k), 32'(N));
        @(negedge clk);
        chk("tbl_done", 32'(done), 1);
      end
    join
    chk("tbl_latency", 32'(t_out0 - t_in0), 2);

    // Five-cycle downstream stall mid-frame
    @(posedge clk);
    #1;
    base = tot_out;
    pulse_start();
    fork
      begin
        for (int i = 0; i < N; i++) send_rand(0);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 100 && tot_out < base + 3; c++) begin
          @(posedge clk);
          #1;
        end
        mode = 1;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 0);
          chk("stall_out_valid", 32'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        mode = 0;
      end
    join
    wait_done();

    // Three back-to-back random frames, each started on the done pulse
    mode = 2;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) send_rand(int'($urandom_range(0, 2)));
      in_valid = 1'b0;
      wait_done();
      if (f < 2) pulse_start();
    end
    mode = 0;

    // Input offered while idle is not consumed
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_r = 8'd10; in_g = 8'd20; in_b = 8'd30;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // start during STREAM must not disturb counters or state
    pulse_start();
    for (int i = 0; i < 3; i++) send_rand(0);
    in_valid = 1'b0;
    pulse_start();
    chk("restart_busy", 32'(busy), 1);
    for (int i = 0; i < N - 3; i++) send_rand(0);
    in_valid = 1'b0;
    wait_done();

    // Input held high during DRAIN is not consumed
    pulse_start();
    for (int i = 0; i < N; i++) send_rand(0);
    mode = 1;
    repeat (4) begin
      @(negedge clk);
      chk("drain_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    mode = 0;
    in_valid = 1'b0;
    wait_done();

    // Reset after five input transfers
    pulse_start();
    for (int i = 0; i < 5; i++) send_rand(0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    @(posedge clk);
    #1;
    chk("midrst_done_later", 32'(done), 0);
    pulse_start();
    fork
      begin
        for (int i = 0; i < N; i++) send_rand(0);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (out_valid) begin
            sof_seen = out_sof;
            break;
          end
        end
        chk("postrst_first_sof", 32'(sof_seen), 1);
      end
    join
    wait_done();

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
